// File: rtl/d_ip_timer_pkg.sv
// Shared constants for the multi-channel timer: register map, CTRL/INT bit
// positions, counting modes, prescaler limit and a byte-select helper.
package d_ip_timer_pkg;

    localparam logic [5:0] ADDR_CTRL     = 6'h00;
    localparam logic [5:0] ADDR_INT_EN   = 6'h01;
    localparam logic [5:0] ADDR_INT_STAT = 6'h02;
    localparam logic [5:0] ADDR_CMD      = 6'h03;
    localparam logic [5:0] ADDR_COUNT    = 6'h04;
    localparam logic [5:0] ADDR_TOP      = 6'h08;
    localparam logic [5:0] ADDR_CMP      = 6'h10;  // CMP i at ADDR_CMP + 4*i
    localparam logic [5:0] ADDR_CAPT     = 6'h30;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_CLK_SEL  = 3;
    localparam int CTRL_PSC_LSB  = 4;
    localparam int CMD_CLEAR     = 0;

    localparam int INT_OVF  = 0;
    localparam int INT_CMP0 = 1;
    localparam int INT_CAPT = 7;

    localparam logic [3:0] PSC_MAX = 4'd11;

    typedef enum logic [1:0] {
        MODE_FREE    = 2'b00,
        MODE_ONESHOT = 2'b01,
        MODE_UPDOWN  = 2'b10,
        MODE_FREE_ALT = 2'b11
    } mode_e;

    function automatic logic [7:0] byte_of(input logic [31:0] v, input logic [1:0] b);
        return v[8*b +: 8];
    endfunction

endpackage

// File: rtl/d_ip_timer_mc_if.sv
// 8-bit peripheral register bus. mod_en strobes one access per cycle,
// wr_en selects write (1) or read (0); rdata is returned by the slave.
interface d_ip_timer_mc_if;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic       wr_en;
    logic       mod_en;
    logic [7:0] rdata;

    modport master (output addr, wdata, wr_en, mod_en, input rdata);
    modport slave  (input addr, wdata, wr_en, mod_en, output rdata);
endinterface

// File: rtl/d_ip_timer_tick_gen.sv
// Count-tick source: synchronises timer_in, detects its rising edge and runs
// the 2^n prescaler.
//  clk, rst   clock, synchronous active-high reset
//  en         timer enable; prescaler held at 0 while low
//  clk_sel    0: prescaled clk, 1: timer_in rising edges
//  clr        CLEAR command, restarts the prescaler
//  psc        prescaler exponent n (values >11 behave as 11)
//  timer_in   asynchronous external input
//  tick       one-cycle count enable
//  in_rise    synchronised rising edge of timer_in (also used for capture)
module d_ip_timer_tick_gen
    import d_ip_timer_pkg::*;
#(
    parameter int SYNC_FF = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clk_sel,
    input  logic       clr,
    input  logic [3:0] psc,
    input  logic       timer_in,
    output logic       tick,
    output logic       in_rise
);
    logic [SYNC_FF-1:0] sync;
    logic               prev;
    logic [PSC_MAX-1:0] pcnt;
    logic [PSC_MAX-1:0] mask;
    logic [3:0]         n;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
            pcnt <= '0;
        end else begin
            sync <= {sync[SYNC_FF-2:0], timer_in};
            prev <= sync[SYNC_FF-1];
            if (clr || !en) pcnt <= '0;
            else            pcnt <= pcnt + 1'b1;
        end
    end

    // Tick when the low n bits of the free-running prescaler are all ones;
    // n=0 gives an empty mask, i.e. a tick every cycle.
    always_comb begin
        n    = (psc > PSC_MAX) ? PSC_MAX : psc;
        mask = PSC_MAX'((12'd1 << n) - 12'd1);
    end

    assign in_rise = sync[SYNC_FF-1] & ~prev;
    assign tick    = en & (clk_sel ? in_rise : ((pcnt & mask) == mask));

endmodule

// File: rtl/d_ip_timer_mc.sv
// Multi-channel timer: COUNT_W-bit counter with programmable TOP, prescaler,
// free-run / one-shot / up-down modes, NUM_CMP compare channels, PWM output
// and per-source interrupts on an 8-bit register bus.
//  clk, rst      clock, synchronous active-high reset
//  bus           register bus (slave modport): addr, wdata, wr_en, mod_en, rdata
//  timer_in      async external count clock / capture trigger
//  overflow_int  INT_STAT[0] & INT_EN[0], registered
//  cmp_int       INT_STAT[1+i] & INT_EN[1+i], registered
//  capture_int   INT_STAT[7] & INT_EN[7], registered
//  timer_out     PWM: high while enabled and COUNT < CMP0, registered
// Optional feature macro: TIMER_CAPTURE_EN (CAPTURE register + capture interrupt).
module d_ip_timer_mc
    import d_ip_timer_pkg::*;
#(
    parameter int COUNT_W = 16,
    parameter int NUM_CMP = 2,
    parameter int SYNC_FF = 2
) (
    input  logic               clk,
    input  logic               rst,
    d_ip_timer_mc_if.slave     bus,
    input  logic               timer_in,
    output logic               overflow_int,
    output logic [NUM_CMP-1:0] cmp_int,
    output logic               capture_int,
    output logic               timer_out
);
    localparam int CNT_BYTES = (COUNT_W + 7) / 8;
    localparam int SW        = CNT_BYTES * 8;
    localparam logic [7:0] CMP_BITS = 8'(((1 << NUM_CMP) - 1) << INT_CMP0);
`ifdef TIMER_CAPTURE_EN
    localparam logic [7:0] STAT_MASK = CMP_BITS | 8'h81;
`else
    localparam logic [7:0] STAT_MASK = CMP_BITS | 8'h01;
`endif

    typedef logic [COUNT_W-1:0] cnt_t;

    logic [7:0]                       ctrl, int_en, int_stat, int_stat_nxt, evt, w1c, rd_byte;
    cnt_t                             count, top, snap, cnt_nxt, wval;
    logic [NUM_CMP-1:0][COUNT_W-1:0]  cmp;
    logic [SW-1:0]                    stage, staged_full;
    logic                             dir_dn, dir_nxt, ovf, os_wrap;
    logic                             tick, tick_eff, in_rise, clr, count_wr;
    logic                             wr, rd, bok, hi_b, sel_cnt, sel_top, sel_cmp;
    logic [1:0]                       bsel;
    int                               cmp_idx;
    mode_e                            mode;

    assign wr      = bus.mod_en & bus.wr_en;
    assign rd      = bus.mod_en & ~bus.wr_en;
    assign bsel    = bus.addr[1:0];
    assign bok     = int'(bsel) < CNT_BYTES;
    assign hi_b    = int'(bsel) == CNT_BYTES - 1;
    assign sel_cnt = bus.addr[5:2] == ADDR_COUNT[5:2] && bok;
    assign sel_top = bus.addr[5:2] == ADDR_TOP[5:2] && bok;
    assign sel_cmp = int'(bus.addr) >= int'(ADDR_CMP) &&
                     int'(bus.addr) < int'(ADDR_CMP) + 4*NUM_CMP && bok;
    assign cmp_idx = int'(bus.addr[5:2]) - int'(ADDR_CMP[5:2]);
    assign clr     = wr && bus.addr == ADDR_CMD && bus.wdata[CMD_CLEAR];
    assign count_wr = wr && sel_cnt && hi_b;
    // A bus commit or CLEAR owns COUNT this cycle; the coincident tick is lost.
    assign tick_eff = tick & ~count_wr & ~clr;
    assign mode    = mode_e'(ctrl[CTRL_MODE_LSB +: 2]);

    d_ip_timer_tick_gen #(.SYNC_FF(SYNC_FF)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .en      (ctrl[CTRL_EN]),
        .clk_sel (ctrl[CTRL_CLK_SEL]),
        .clr     (clr),
        .psc     (ctrl[CTRL_PSC_LSB +: 4]),
        .timer_in(timer_in),
        .tick    (tick),
        .in_rise (in_rise)
    );

    // Highest byte write commits the lower staged bytes together with wdata.
    always_comb begin
        staged_full = stage;
        staged_full[SW-1 -: 8] = bus.wdata;
        wval = staged_full[COUNT_W-1:0];
    end

    // Next count on a tick. A COUNT above TOP never equals TOP, so it simply
    // keeps incrementing and wraps naturally at all-ones.
    always_comb begin
        cnt_nxt = count + cnt_t'(1);
        dir_nxt = dir_dn;
        ovf     = 1'b0;
        if (top == '0) begin
            cnt_nxt = '0;
            ovf     = 1'b1;
        end else if (mode == MODE_UPDOWN) begin
            if (dir_dn) begin
                if (count == '0) begin
                    dir_nxt = 1'b0;
                    ovf     = 1'b1;
                end else begin
                    cnt_nxt = count - cnt_t'(1);
                end
            end else if (count == top) begin
                cnt_nxt = count - cnt_t'(1);
                dir_nxt = 1'b1;
            end
        end else if (count == top) begin
            cnt_nxt = '0;
            ovf     = 1'b1;
        end
        os_wrap = ovf && mode == MODE_ONESHOT;
    end

    // Events; bit 7 is stripped by STAT_MASK when capture is not built in.
    always_comb begin
        evt = '0;
        evt[INT_OVF] = tick_eff & ovf;
        for (int i = 0; i < NUM_CMP; i++)
            evt[INT_CMP0+i] = tick_eff && cnt_nxt == cmp[i] && cmp[i] <= top;
        evt[INT_CAPT] = in_rise & ~ctrl[CTRL_CLK_SEL];
        w1c = (wr && bus.addr == ADDR_INT_STAT) ? bus.wdata : 8'h00;
        int_stat_nxt = ((int_stat & ~w1c) | evt) & STAT_MASK;  // set beats clear
    end

`ifdef TIMER_CAPTURE_EN
    cnt_t capt;
    always_ff @(posedge clk) begin
        if (rst)                                  capt <= '0;
        else if (in_rise && !ctrl[CTRL_CLK_SEL])  capt <= count;
    end
`endif

    always_comb begin
        rd_byte = 8'h00;
        case (bus.addr)
            ADDR_CTRL:     rd_byte = ctrl;
            ADDR_INT_EN:   rd_byte = int_en;
            ADDR_INT_STAT: rd_byte = int_stat;
            default:       ;
        endcase
        // Byte 0 reads live and snapshots; upper bytes come from the snapshot.
        if (sel_cnt) rd_byte = (bsel == 2'd0) ? byte_of(32'(count), 2'd0) : byte_of(32'(snap), bsel);
        if (sel_top) rd_byte = byte_of(32'(top), bsel);
        for (int i = 0; i < NUM_CMP; i++)
            if (sel_cmp && cmp_idx == i) rd_byte = byte_of(32'(cmp[i]), bsel);
`ifdef TIMER_CAPTURE_EN
        if (bus.addr[5:2] == ADDR_CAPT[5:2] && bok) rd_byte = byte_of(32'(capt), bsel);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl         <= '0;
            int_en       <= '0;
            int_stat     <= '0;
            count        <= '0;
            top          <= '0;
            cmp          <= '0;
            stage        <= '0;
            snap         <= '0;
            dir_dn       <= 1'b0;
            bus.rdata    <= '0;
            overflow_int <= 1'b0;
            cmp_int      <= '0;
            capture_int  <= 1'b0;
            timer_out    <= 1'b0;
        end else begin
            if (tick_eff) begin
                count  <= cnt_nxt;
                dir_dn <= dir_nxt;
                if (os_wrap) ctrl[CTRL_EN] <= 1'b0;
            end
            int_stat <= int_stat_nxt;

            if (rd) begin
                bus.rdata <= rd_byte;
                if (sel_cnt && bsel == 2'd0) snap <= count;
            end

            if (wr) begin
                if (bus.addr == ADDR_CTRL)   ctrl   <= bus.wdata;
                if (bus.addr == ADDR_INT_EN) int_en <= bus.wdata & STAT_MASK;
                if (sel_cnt || sel_top || sel_cmp) begin
                    if (hi_b) begin
                        if (sel_cnt) count <= wval;
                        if (sel_top) top   <= wval;
                        for (int i = 0; i < NUM_CMP; i++)
                            if (sel_cmp && cmp_idx == i) cmp[i] <= wval;
                    end else begin
                        stage[8*int'(bsel) +: 8] <= bus.wdata;
                    end
                end
            end
            if (clr) begin
                count  <= '0;
                dir_dn <= 1'b0;
            end

            overflow_int <= int_stat[INT_OVF] & int_en[INT_OVF];
            for (int i = 0; i < NUM_CMP; i++)
                cmp_int[i] <= int_stat[INT_CMP0+i] & int_en[INT_CMP0+i];
            capture_int  <= int_stat[INT_CAPT] & int_en[INT_CAPT];
            timer_out    <= ctrl[CTRL_EN] & (count < cmp[0]);
        end
    end

endmodule

// File: tb/tb_d_ip_timer_mc.sv
module tb_d_ip_timer_mc;
    logic       clk = 1'b0;
    logic       rst;
    logic       timer_in;
    logic       overflow_int, capture_int, timer_out;
    logic [1:0] cmp_int;
    int         checks = 0;
    int         errors = 0;

    d_ip_timer_mc_if bus();

    d_ip_timer_mc #(.COUNT_W(16), .NUM_CMP(2), .SYNC_FF(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .timer_in    (timer_in),
        .overflow_int(overflow_int),
        .cmp_int     (cmp_int),
        .capture_int (capture_int),
        .timer_out   (timer_out)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [5:0] addr;
        logic [7:0] data;   // write data, or expected read data
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge; one access per cycle.
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_wr(input logic [5:0] a, input logic [7:0] d);
        bus.addr = a; bus.wdata = d; bus.wr_en = 1'b1; bus.mod_en = 1'b1;
        @(negedge clk);
        bus.mod_en = 1'b0; bus.wr_en = 1'b0;
    endtask

    task automatic bus_rd(input logic [5:0] a, output logic [7:0] d);
        bus.addr = a; bus.wr_en = 1'b0; bus.mod_en = 1'b1;
        @(negedge clk);
        d = bus.rdata;
        bus.mod_en = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [5:0] a, input logic [7:0] e);
        logic [7:0] d;
        bus_rd(a, d);
        chk(nm, d, e);
    endtask

    // EN off, CLEAR, flush status, program TOP/CMP0/CMP1 and INT_EN.
    task automatic setup(input logic [15:0] t, input logic [15:0] c0, input logic [15:0] c1,
                         input logic [7:0] ie);
        bus_wr(6'h00, 8'h00);
        bus_wr(6'h03, 8'h01);
        bus_wr(6'h02, 8'hFF);
        bus_wr(6'h08, t[7:0]);  bus_wr(6'h09, t[15:8]);
        bus_wr(6'h10, c0[7:0]); bus_wr(6'h11, c0[15:8]);
        bus_wr(6'h14, c1[7:0]); bus_wr(6'h15, c1[15:8]);
        bus_wr(6'h01, ie);
    endtask

    vec_t       vecs[$];
    logic [7:0] d;
    logic [7:0] ud_exp[10] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd2, 8'd1, 8'd0, 8'd1, 8'd2, 8'd3};
`ifdef TIMER_CAPTURE_EN
    localparam logic [7:0] IE_ALL = 8'h87;
`else
    localparam logic [7:0] IE_ALL = 8'h07;
`endif

    initial begin
        rst = 1'b1; timer_in = 1'b0;
        bus.addr = '0; bus.wdata = '0; bus.wr_en = 1'b0; bus.mod_en = 1'b0;
        idle(3);
        rst = 1'b0;
        chk("rst_ovf", overflow_int, 0);
        chk("rst_cmp", cmp_int, 0);
        chk("rst_cap", capture_int, 0);
        chk("rst_pwm", timer_out, 0);
        chk("rst_rdata", bus.rdata, 0);

        // Register map / staging vectors, all with EN=0.
        vecs.push_back('{1'b0, 6'h00, 8'h00});
        vecs.push_back('{1'b0, 6'h04, 8'h00});
        vecs.push_back('{1'b1, 6'h08, 8'h34});
        vecs.push_back('{1'b0, 6'h08, 8'h00});   // staged only
        vecs.push_back('{1'b1, 6'h09, 8'h12});
        vecs.push_back('{1'b0, 6'h08, 8'h34});
        vecs.push_back('{1'b0, 6'h09, 8'h12});
        vecs.push_back('{1'b1, 6'h04, 8'hCD});
        vecs.push_back('{1'b0, 6'h04, 8'h00});   // low byte alone leaves COUNT
        vecs.push_back('{1'b0, 6'h05, 8'h00});
        vecs.push_back('{1'b1, 6'h05, 8'hAB});
        vecs.push_back('{1'b0, 6'h04, 8'hCD});
        vecs.push_back('{1'b0, 6'h05, 8'hAB});
        vecs.push_back('{1'b1, 6'h01, 8'hFF});
        vecs.push_back('{1'b0, 6'h01, IE_ALL});
        vecs.push_back('{1'b1, 6'h00, 8'hF6});
        vecs.push_back('{1'b0, 6'h00, 8'hF6});
        vecs.push_back('{1'b1, 6'h00, 8'h00});
        vecs.push_back('{1'b1, 6'h10, 8'h55});
        vecs.push_back('{1'b1, 6'h11, 8'h66});
        vecs.push_back('{1'b1, 6'h14, 8'h77});
        vecs.push_back('{1'b1, 6'h15, 8'h01});
        vecs.push_back('{1'b0, 6'h10, 8'h55});
        vecs.push_back('{1'b0, 6'h11, 8'h66});
        vecs.push_back('{1'b0, 6'h14, 8'h77});
        vecs.push_back('{1'b0, 6'h15, 8'h01});
        vecs.push_back('{1'b0, 6'h18, 8'h00});   // no CMP2
        vecs.push_back('{1'b0, 6'h06, 8'h00});   // beyond CNT_BYTES
        vecs.push_back('{1'b1, 6'h20, 8'h99});
        vecs.push_back('{1'b0, 6'h20, 8'h00});
        vecs.push_back('{1'b0, 6'h30, 8'h00});
        vecs.push_back('{1'b0, 6'h02, 8'h00});
        vecs.push_back('{1'b1, 6'h03, 8'h01});   // CLEAR
        vecs.push_back('{1'b0, 6'h04, 8'h00});
        vecs.push_back('{1'b0, 6'h05, 8'h00});
        vecs.push_back('{1'b0, 6'h03, 8'h00});
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) bus_wr(vecs[i].addr, vecs[i].data);
            else            rd_chk($sformatf("vec%0d_a%0h", i, vecs[i].addr), vecs[i].addr, vecs[i].data);
        end
        idle(2);
        chk("rdata_hold", bus.rdata, 8'h00);

        // Free-run TOP=9: overflow at the 10th tick, output one cycle later.
        setup(16'd9, 16'd100, 16'd200, 8'h01);
        bus_wr(6'h00, 8'h01);
        idle(10);
        chk("ovf_early", overflow_int, 0);
        idle(1);
        chk("ovf_set", overflow_int, 1);
        bus_wr(6'h00, 8'h00);
        rd_chk("ovf_stat", 6'h02, 8'h01);
        bus_wr(6'h02, 8'h01);
        chk("ovf_lag", overflow_int, 1);
        idle(1);
        chk("ovf_w1c", overflow_int, 0);
        rd_chk("ovf_stopcnt", 6'h04, 8'h02);

        // Compare channels and PWM, TOP=9, CMP0=3, CMP1=7.
        setup(16'd9, 16'd3, 16'd7, 8'h06);
        bus_wr(6'h00, 8'h01);
        for (int k = 1; k <= 14; k++) begin
            idle(1);
            chk($sformatf("cmp_k%0d", k), cmp_int, {1'(k >= 8), 1'(k >= 4)});
            chk($sformatf("pwm_k%0d", k), timer_out, 1'(((k - 1) % 10) < 3));
        end

        // Reset mid-count.
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("mrst_cmp", cmp_int, 0);
        chk("mrst_pwm", timer_out, 0);
        chk("mrst_ovf", overflow_int, 0);
        rd_chk("mrst_ctrl", 6'h00, 8'h00);
        rd_chk("mrst_cnt", 6'h04, 8'h00);

        // One-shot TOP=4.
        setup(16'd4, 16'd3, 16'd7, 8'h00);
        bus_wr(6'h00, 8'h03);
        idle(3);
        rd_chk("os_mid", 6'h04, 8'h03);
        idle(4);
        rd_chk("os_ctrl", 6'h00, 8'h02);
        rd_chk("os_cnt", 6'h04, 8'h00);
        rd_chk("os_stat", 6'h02, 8'h03);

        // Up-down TOP=3; CMP1=7 > TOP never matches.
        setup(16'd3, 16'd3, 16'd7, 8'h00);
        bus_wr(6'h00, 8'h05);
        for (int k = 0; k < 10; k++) rd_chk($sformatf("ud_%0d", k), 6'h04, ud_exp[k]);
        rd_chk("ud_stat", 6'h02, 8'h03);

        // TOP=0: COUNT held, overflow every tick.
        setup(16'd0, 16'd5, 16'd5, 8'h00);
        bus_wr(6'h00, 8'h01);
        idle(3);
        rd_chk("top0_cnt", 6'h04, 8'h00);
        rd_chk("top0_stat", 6'h02, 8'h01);

        // Prescaler n=2: one tick per 4 clocks.
        setup(16'hFFFF, 16'hFFFF, 16'hFFFF, 8'h00);
        bus_wr(6'h00, 8'h21);
        idle(8);
        rd_chk("psc2", 6'h04, 8'h02);

        // Snapshot consistency and commit beating a tick.
        setup(16'hFFFF, 16'hFFFF, 16'hFFFF, 8'h00);
        bus_wr(6'h04, 8'hFE);
        bus_wr(6'h05, 8'h00);
        bus_wr(6'h00, 8'h01);
        idle(1);
        rd_chk("snap_lo", 6'h04, 8'hFF);
        rd_chk("snap_hi", 6'h05, 8'h00);
        bus_wr(6'h04, 8'h10);
        bus_wr(6'h05, 8'h20);
        rd_chk("commit_lo", 6'h04, 8'h10);
        rd_chk("commit_hi", 6'h05, 8'h20);

        // CLK_SEL=1: SYNC_FF+1 latency, one count per timer_in period.
        setup(16'hFFFF, 16'hFFFF, 16'hFFFF, 8'h00);
        bus_wr(6'h00, 8'h09);
        timer_in = 1'b1;
        idle(2);
        rd_chk("ext_lat0", 6'h04, 8'h00);
        rd_chk("ext_lat1", 6'h04, 8'h01);
        timer_in = 1'b0;
        idle(5);
        for (int p = 0; p < 4; p++) begin
            timer_in = 1'b1; #100;
            timer_in = 1'b0; #100;
        end
        idle(10);
        rd_chk("ext_cnt", 6'h04, 8'h05);
        idle(20);
        rd_chk("ext_stall", 6'h04, 8'h05);

`ifdef TIMER_CAPTURE_EN
        setup(16'hFFFF, 16'hFFFF, 16'hFFFF, 8'h80);
        bus_wr(6'h00, 8'h01);
        timer_in = 1'b1;
        idle(5);
        rd_chk("capt_lo", 6'h30, 8'h02);
        rd_chk("capt_hi", 6'h31, 8'h00);
        chk("capt_int", capture_int, 1);
        timer_in = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
